// File: rtl/stream_demux_4_pkg.sv
// Shared definitions for the 1-to-4 buffered stream demultiplexer.
package stream_demux_4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel, with a saturating
// accepted-word counter.
module demux_slot #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop_ready,
  input  logic             cnt_clr,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             ready_for_load,
  output logic [CNT_W-1:0] cnt
);

  assign ready_for_load = !full || pop_ready;

  // A load wins over a same-cycle pop so the slot stays full: 1 word/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && pop_ready) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (load && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_demux_4.sv
// Buffered 1-to-4 stream demultiplexer: routes each input word to the
// channel named by in_sel, each channel having its own one-entry slot.
module stream_demux_4
  import stream_demux_4_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  input  logic                      cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]   cnt
);

  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] load;
  logic              accept;
  sel_t              sel;

  assign sel = in_sel;

  // Only combinational input-to-output path: in_ready follows in_sel/out_ready.
  assign in_ready = rdy[sel];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = accept && (sel == sel_t'(i));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk            (clk),
      .rst_n          (rst_n),
      .load           (load[i]),
      .load_data      (in_data),
      .pop_ready      (out_ready[i]),
      .cnt_clr        (cnt_clr),
      .full           (out_valid[i]),
      .data           (out_data[i*WIDTH +: WIDTH]),
      .ready_for_load (rdy[i]),
      .cnt            (cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_4.sv
// Scoreboard bench for stream_demux_4: expected words queued per channel at
// acceptance, popped and compared by a monitor whenever a channel hands one off.
module tb_stream_demux_4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic          cnt_clr = 1'b0;
  logic [63:0]   cnt;

  logic [31:0]   s_in_data = '0;
  logic [1:0]    s_in_sel = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [127:0]  s_out_data;
  logic [3:0]    s_out_valid;
  logic [3:0]    s_out_ready = 4'b1111;
  logic          s_cnt_clr = 1'b0;
  logic [15:0]   s_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] q [4][$];

  always #5 clk = ~clk;

  stream_demux_4 #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt(cnt)
  );

  stream_demux_4 #(.WIDTH(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_sel(s_in_sel),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .cnt_clr(s_cnt_clr), .cnt(s_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] s, input logic [31:0] d, input bit must_ready);
    int n;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    n = 0;
    @(negedge clk);
    if (must_ready) chk("in_ready_now", 128'(in_ready), 128'(1));
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 128'(0), 128'(1));
    else q[s].push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("unexpected_ch%0d", i), 128'(out_data[i*32 +: 32]), 128'hFFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("data_ch%0d", i), 128'(out_data[i*32 +: 32]), 128'(q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_data",  out_data, 128'(0));
    chk("reset_cnt",   128'(cnt), 128'(0));
    @(posedge clk); #1;

    // Single word to ch2, then back-pressure on a second ch2 word
    send(2'd2, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t1_valid",  128'(out_valid), 128'(4'b0100));
    chk("t1_data2",  128'(out_data[64 +: 32]), 128'(32'hDEADBEEF));
    chk("t1_cnt2",   128'(cnt[32 +: 16]), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h11;
    repeat (2) begin
      @(negedge clk);
      chk("t1_stall", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 4'b0100;
    send(2'd2, 32'h11, 1'b1);
    out_ready = 4'b1111;
    repeat (3) @(posedge clk); #1;

    // Clear, then round-robin streaming at full rate
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 128'(cnt), 128'(0));
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) send(2'(k % 4), 32'(k + 1), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rr_cnt", 128'(cnt), 128'h0002_0002_0002_0002);
    @(posedge clk); #1;

    // Stalled ch1 must not block ch3
    out_ready = 4'b1101;
    send(2'd1, 32'hA1, 1'b1);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hA2;
    repeat (2) begin
      @(negedge clk);
      chk("ch1_stall", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) send(2'd3, 32'hC0 + 32'(k), 1'b1);
    out_ready = 4'b1111;
    send(2'd1, 32'hA2, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Same-cycle pop and load on ch0
    out_ready = 4'b1110;
    send(2'd0, 32'hA, 1'b1);
    out_ready = 4'b1111;
    send(2'd0, 32'h5, 1'b1);
    @(negedge clk);
    chk("pl_valid0", 128'(out_valid[0]), 128'(1));
    chk("pl_data0",  128'(out_data[31:0]), 128'(32'h5));
    repeat (3) @(posedge clk); #1;

    // Counter saturation on the CNT_W=4 instance
    for (int k = 0; k < 20; k++) begin
      s_in_valid = 1'b1; s_in_sel = 2'd1; s_in_data = 32'(k);
      @(posedge clk); #1;
      if (k == 14) chk("sat_at15", 128'(s_cnt[7:4]), 128'(15));
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_hold", 128'(s_cnt[7:4]), 128'(15));
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_cnt_clr = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_prio", 128'(s_cnt[7:4]), 128'(0));
    @(posedge clk); #1;

    // Asynchronous reset with slots full
    out_ready = 4'b0000;
    send(2'd0, 32'h1A, 1'b1);
    send(2'd1, 32'h2B, 1'b1);
    send(2'd3, 32'h3C, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_data",  out_data, 128'(0));
    chk("arst_cnt",   128'(cnt), 128'(0));
    for (int i = 0; i < 4; i++) q[i].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    send(2'd2, 32'h77, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("drained_ch%0d", i), 128'(q[i].size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
